// File: rtl/card_dealer_if.sv
// ============================================================================
// Module      : card_dealer_if
// Description : Request/deal signal bundle between a requester and card_dealer.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface card_dealer_if;
    logic       shuffle;
    logic       card_req;
    logic       card_valid;
    logic [3:0] card_value;
    logic [1:0] card_symbol;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       card_err;
    logic       busy;

    modport master (
        output shuffle, card_req,
        input  card_valid, card_value, card_symbol, cards_left,
               deck_empty, card_err, busy
    );

    modport slave (
        input  shuffle, card_req,
        output card_valid, card_value, card_symbol, cards_left,
               deck_empty, card_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/card_dealer.sv
// ============================================================================
// Module      : card_dealer
// Description : Deals unique cards from a 52-card deck using an LFSR start
//               point and a linear probe over a used-card bitmap.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    card_dealer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] C_DECK_SIZE = 6'd52;
    localparam logic [5:0] C_LAST_IDX  = 6'd51;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [51:0] r_used;
    logic [5:0]  r_cand;
    logic [5:0]  r_left;
    logic [3:0]  r_value;
    logic [1:0]  r_symbol;
    logic        r_err;

    logic        w_fb;
    logic [5:0]  w_start;
    logic [5:0]  w_next_cand;
    logic [1:0]  w_sym;
    logic [5:0]  w_rem;

    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_start     = (r_lfsr[5:0] < C_DECK_SIZE) ? r_lfsr[5:0]
                                                     : r_lfsr[5:0] - C_DECK_SIZE;
    assign w_next_cand = (r_cand == C_LAST_IDX) ? 6'd0 : r_cand + 6'd1;

    // Index to suit/rank split without a divider.
    always_comb begin
        w_sym = 2'd0;
        w_rem = r_cand;
        if (r_cand < 6'd13) begin
            w_sym = 2'd0;
            w_rem = r_cand;
        end else if (r_cand < 6'd26) begin
            w_sym = 2'd1;
            w_rem = r_cand - 6'd13;
        end else if (r_cand < 6'd39) begin
            w_sym = 2'd2;
            w_rem = r_cand - 6'd26;
        end else begin
            w_sym = 2'd3;
            w_rem = r_cand - 6'd39;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lfsr   <= SEED;
            r_used   <= '0;
            r_cand   <= '0;
            r_left   <= C_DECK_SIZE;
            r_value  <= '0;
            r_symbol <= '0;
            r_err    <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.shuffle) begin
                        r_used <= '0;
                        r_left <= C_DECK_SIZE;
                    end else if (bus.card_req) begin
                        if (r_left != 6'd0) begin
                            r_cand  <= w_start;
                            r_state <= PROBE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                PROBE: begin
                    if (bus.shuffle) begin
                        r_used  <= '0;
                        r_left  <= C_DECK_SIZE;
                        r_state <= IDLE;
                    end else if (r_used[r_cand]) begin
                        r_cand <= w_next_cand;
                    end else begin
                        r_used[r_cand] <= 1'b1;
                        r_left         <= r_left - 6'd1;
                        r_value        <= w_rem[3:0] + 4'd1;
                        r_symbol       <= w_sym;
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.shuffle) begin
                        r_used <= '0;
                        r_left <= C_DECK_SIZE;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A shuffle arriving in DONE suppresses the pulse so an aborted draw is never seen.
    assign bus.card_valid  = (r_state == DONE) && !bus.shuffle;
    assign bus.card_value  = r_value;
    assign bus.card_symbol = r_symbol;
    assign bus.cards_left  = r_left;
    assign bus.deck_empty  = (r_left == 6'd0);
    assign bus.card_err    = r_err;
    assign bus.busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_card_dealer.sv
// ============================================================================
// Module      : tb_card_dealer
// Description : Scoreboard bench for card_dealer: driver predicts each deal,
//               monitor checks every card_valid / card_err event.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    card_dealer_if bus ();

    card_dealer #(.SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [3:0] val;
        logic [1:0] sym;
        logic [5:0] left;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left;
    logic [3:0]  last_val;
    logic [1:0]  last_sym;
    bit          seen[52];
    int          mon_idx;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, advancing whenever rst is low.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.card_valid || bus.card_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: valid=%0b err=%0b expected none (cycle %0d)",
                         bus.card_valid, bus.card_err, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind_err", int'(bus.card_err), int'(mon_e.is_err));
                chk("event_kind_valid", int'(bus.card_valid), int'(!mon_e.is_err));
                chk("event_cycle", cyc, mon_e.cyc);
                chk("card_value", int'(bus.card_value), int'(mon_e.val));
                chk("card_symbol", int'(bus.card_symbol), int'(mon_e.sym));
                chk("cards_left", int'(bus.cards_left), int'(mon_e.left));
                if (bus.card_valid && bus.card_value >= 4'd1 && bus.card_value <= 4'd13) begin
                    mon_idx = int'(bus.card_symbol) * 13 + int'(bus.card_value) - 1;
                    chk("card_distinct", int'(seen[mon_idx]), 0);
                    seen[mon_idx] = 1'b1;
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 52; i++) begin
            m_used[i] = 1'b0;
            seen[i]   = 1'b0;
        end
        m_left = 52;
    endtask

    task automatic wait_idle();
        int n;
        @(negedge clk);
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=1 expected 0 within 100 cycles");
        end
    endtask

    task automatic draw();
        int   c;
        int   k;
        exp_t e;
        wait_idle();
        bus.card_req = 1'b1;
        if (m_left == 0) begin
            e = '{is_err: 1'b1, cyc: cyc + 1, val: last_val, sym: last_sym, left: 6'd0};
        end else begin
            c = int'(m_lfsr[5:0]);
            if (c >= 52) c -= 52;
            k = 0;
            while (m_used[c]) begin
                c = (c == 51) ? 0 : c + 1;
                k++;
            end
            m_used[c] = 1'b1;
            m_left--;
            last_val = 4'(c % 13 + 1);
            last_sym = 2'(c / 13);
            e = '{is_err: 1'b0, cyc: cyc + 2 + k, val: last_val, sym: last_sym, left: 6'(m_left)};
        end
        q.push_back(e);
        @(negedge clk);
        bus.card_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        bus.shuffle  = 1'b0;
        bus.card_req = 1'b0;
        last_val     = '0;
        last_sym     = '0;
        clear_model();
        repeat (3) @(negedge clk);

        chk("reset_valid", int'(bus.card_valid), 0);
        chk("reset_err", int'(bus.card_err), 0);
        chk("reset_left", int'(bus.cards_left), 52);
        chk("reset_empty", int'(bus.deck_empty), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_value", int'(bus.card_value), 0);
        chk("reset_symbol", int'(bus.card_symbol), 0);
        rst = 1'b0;

        // First draw from a full deck: no probe skips, busy for exactly two cycles.
        draw();
        chk("first_busy_n1", int'(bus.busy), 1);
        @(negedge clk);
        chk("first_busy_n2", int'(bus.busy), 1);
        @(negedge clk);
        chk("first_busy_n3", int'(bus.busy), 0);
        drain();

        for (int i = 1; i < 52; i++) draw();
        drain();
        chk("full_deal_left", int'(bus.cards_left), 0);
        chk("full_deal_empty", int'(bus.deck_empty), 1);

        draw();
        drain();
        @(negedge clk);
        chk("empty_left", int'(bus.cards_left), 0);
        chk("empty_value_held", int'(bus.card_value), int'(last_val));
        chk("empty_symbol_held", int'(bus.card_symbol), int'(last_sym));

        wait_idle();
        bus.shuffle = 1'b1;
        clear_model();
        @(negedge clk);
        bus.shuffle = 1'b0;
        chk("shuffle_left", int'(bus.cards_left), 52);
        chk("shuffle_empty", int'(bus.deck_empty), 0);

        // Shuffle while probing aborts the draw.
        for (int i = 0; i < 3; i++) draw();
        drain();
        wait_idle();
        bus.card_req = 1'b1;
        @(negedge clk);
        bus.card_req = 1'b0;
        bus.shuffle  = 1'b1;
        clear_model();
        @(negedge clk);
        bus.shuffle = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_left", int'(bus.cards_left), 52);
        @(negedge clk);
        chk("abort_no_restart", int'(bus.busy), 0);
        draw();
        drain();

        // Shuffle and request together in IDLE: shuffle wins, no draw starts.
        draw();
        drain();
        wait_idle();
        bus.shuffle  = 1'b1;
        bus.card_req = 1'b1;
        clear_model();
        @(negedge clk);
        bus.shuffle  = 1'b0;
        bus.card_req = 1'b0;
        chk("shuf_req_left", int'(bus.cards_left), 52);
        chk("shuf_req_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);

        // Reset in PROBE discards the draw and reloads the LFSR seed.
        draw();
        q.delete();
        rst = 1'b1;
        clear_model();
        last_val = '0;
        last_sym = '0;
        @(negedge clk);
        chk("rst_probe_busy", int'(bus.busy), 0);
        chk("rst_probe_valid", int'(bus.card_valid), 0);
        chk("rst_probe_left", int'(bus.cards_left), 52);
        chk("rst_probe_value", int'(bus.card_value), 0);
        chk("rst_probe_symbol", int'(bus.card_symbol), 0);
        rst = 1'b0;
        draw();
        draw();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
